// File: rtl/wb_write_queue.sv
// wb_write_queue: circular writeback queue between execute and the register file.
// Requests carrying {dest, value} are queued and drained one per cycle whenever
// the register file allows it (drain_en). Writes to register 0 are accepted and
// dropped.
// Optional feature: define WBQ_FORWARD_EN to compile in the lookup path that
// lets decode see the youngest pending value for a register. Without it the
// lookup outputs are tied to zero.
module wb_write_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_dest,
  input  logic [DATA_W-1:0]        in_val,
  input  logic                     drain_en,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_dest,
  output logic [DATA_W-1:0]        rf_val,
  input  logic [ADDR_W-1:0]        lookup_addr,
  output logic                     lookup_hit,
  output logic [DATA_W-1:0]        lookup_val,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] dest_mem [DEPTH];
  logic [DATA_W-1:0] val_mem  [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic              push;
  logic              pop;

  // Ready depends only on registered occupancy, so a pop in the same cycle
  // never opens a slot for a push into a full queue.
  assign in_ready = (count < CNT_W'(DEPTH));

  // A handshake on register 0 completes but stores nothing.
  assign push = in_valid && in_ready && (in_dest != '0);

  assign rf_we = (count != '0) && drain_en;
  assign pop   = rf_we;

  // The head slot is only exposed while it holds a live entry.
  assign rf_dest = (count != '0) ? dest_mem[head] : '0;
  assign rf_val  = (count != '0) ? val_mem[head]  : '0;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Entry storage written at the tail on every push.
  // NOTE: the storage array has no reset; occupancy gates every read, so stale
  // contents are never visible and the array stays plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      dest_mem[tail] <= in_dest;
      val_mem[tail]  <= in_val;
    end
  end

`ifdef WBQ_FORWARD_EN
  // Scan occupied entries oldest to youngest so the youngest match wins; the
  // head entry is included even while it is being popped this cycle.
  // NOTE: outputs get defaults before the loop so no path can infer a latch.
  always_comb begin
    lookup_hit = 1'b0;
    lookup_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count) && (lookup_addr != '0) &&
          (dest_mem[head + PTR_W'(i)] == lookup_addr)) begin
        lookup_hit = 1'b1;
        lookup_val = val_mem[head + PTR_W'(i)];
      end
    end
  end
`else
  logic unused_lookup_addr;

  // Forwarding compiled out: lookup outputs are constant and the probe
  // address is deliberately left unconnected.
  assign lookup_hit         = 1'b0;
  assign lookup_val         = '0;
  assign unused_lookup_addr = ^lookup_addr;
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// Self-checking bench for wb_write_queue (default parameters). A queue-based
// reference model tracks pending writes; directed scenarios are followed by a
// randomized run compared against that model every cycle.
module tb_wb_write_queue;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] val;
  } ent_t;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_dest;
  logic [DATA_W-1:0] in_val;
  logic              drain_en;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_dest;
  logic [DATA_W-1:0] rf_val;
  logic [ADDR_W-1:0] lookup_addr;
  logic              lookup_hit;
  logic [DATA_W-1:0] lookup_val;
  logic [2:0]        count;

  int n_checks = 0;
  int n_fail   = 0;

  ent_t q[$];

  wb_write_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_dest     (in_dest),
    .in_val      (in_val),
    .drain_en    (drain_en),
    .rf_we       (rf_we),
    .rf_dest     (rf_dest),
    .rf_val      (rf_val),
    .lookup_addr (lookup_addr),
    .lookup_hit  (lookup_hit),
    .lookup_val  (lookup_val),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model step: what the queue does at the coming edge.
  task automatic tick();
    bit ready;
    ready = (q.size() < DEPTH);
    if (q.size() != 0 && drain_en) q.delete(0);
    if (in_valid && ready && in_dest != '0) q.push_back('{dest: in_dest, val: in_val});
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after inputs change.
  task automatic settle();
    #2;
  endtask

  // Youngest pending value for addr, from the model.
  task automatic model_lookup(input logic [ADDR_W-1:0] addr,
                              output logic hit, output logic [DATA_W-1:0] val);
    hit = 1'b0;
    val = '0;
`ifdef WBQ_FORWARD_EN
    if (addr != '0) begin
      foreach (q[i]) begin
        if (q[i].dest == addr) begin
          hit = 1'b1;
          val = q[i].val;
        end
      end
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; drain_en = 1'b1; in_valid = 1'b0; in_dest = '0; in_val = '0;
    lookup_addr = 5'd3;
    settle();
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", rf_we); end
    n_checks++; if (lookup_hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit: got %b want 0", lookup_hit); end
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
  endtask

  task automatic test_single();
    drain_en = 1'b1; in_valid = 1'b1; in_dest = 5'd3; in_val = 32'hDEADBEEF;
    settle();
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL single_pre_we: got %b want 0", rf_we); end
    tick();
    in_valid = 1'b0;
    settle();
    n_checks++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL single_we: got %b want 1", rf_we); end
    n_checks++; if (rf_dest !== 5'd3) begin n_fail++; $display("FAIL single_dest: got %0d want 3", rf_dest); end
    n_checks++; if (rf_val !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_val: got %h want deadbeef", rf_val); end
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL single_count1: got %0d want 1", count); end
    tick();
    settle();
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL single_count0: got %0d want 0", count); end
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL single_we_after: got %b want 0", rf_we); end
  endtask

  task automatic test_fill_full();
    logic [DATA_W-1:0] vals [5];
    drain_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      vals[k]  = $urandom;
      in_valid = 1'b1; in_dest = ADDR_W'(k + 1); in_val = vals[k];
      settle();
      n_checks++;
      if (in_ready !== (k < 4)) begin n_fail++; $display("FAIL fill_ready[%0d]: got %b want %b", k, in_ready, k < 4); end
      if (k < 4) tick();
    end
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_count: got %0d want 4", count); end
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL fill_we_held: got %b want 0", rf_we); end
    // Fifth request stays presented; open the drain and watch the order.
    drain_en = 1'b1;
    for (int j = 0; j < 5; j++) begin
      settle();
      if (j == 0) begin
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_pop_ready: got %b want 0", in_ready); end
      end
      n_checks++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL drain_we[%0d]: got %b want 1", j, rf_we); end
      n_checks++; if (rf_dest !== ADDR_W'(j + 1)) begin n_fail++; $display("FAIL drain_dest[%0d]: got %0d want %0d", j, rf_dest, j + 1); end
      n_checks++; if (rf_val !== vals[j]) begin n_fail++; $display("FAIL drain_val[%0d]: got %h want %h", j, rf_val, vals[j]); end
      if (in_valid && in_ready) begin
        tick();
        in_valid = 1'b0;
      end else begin
        tick();
      end
    end
    settle();
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL drain_empty: got %0d want 0", count); end
  endtask

  task automatic test_dest_zero();
    drain_en = 1'b1; in_valid = 1'b1; in_dest = '0; in_val = 32'h1234;
    for (int k = 0; k < 3; k++) begin
      settle();
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL zero_ready[%0d]: got %b want 1", k, in_ready); end
      n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL zero_we[%0d]: got %b want 0", k, rf_we); end
      tick();
      n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL zero_count[%0d]: got %0d want 0", k, count); end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_forward();
    logic              exp_hit;
    logic [DATA_W-1:0] exp_val;
    ent_t              seq [3];
    seq[0] = '{dest: 5'd9, val: 32'h33};
    seq[1] = '{dest: 5'd7, val: 32'h11};
    seq[2] = '{dest: 5'd7, val: 32'h22};
    drain_en = 1'b0;
    foreach (seq[i]) begin
      in_valid = 1'b1; in_dest = seq[i].dest; in_val = seq[i].val;
      settle();
      tick();
    end
    in_valid = 1'b0;
`ifdef WBQ_FORWARD_EN
    exp_hit = 1'b1; exp_val = 32'h22;
`else
    exp_hit = 1'b0; exp_val = '0;
`endif
    lookup_addr = 5'd7;
    settle();
    n_checks++; if (lookup_hit !== exp_hit) begin n_fail++; $display("FAIL fwd7_hit: got %b want %b", lookup_hit, exp_hit); end
    n_checks++; if (lookup_val !== exp_val) begin n_fail++; $display("FAIL fwd7_val: got %h want %h", lookup_val, exp_val); end
    lookup_addr = 5'd8;
    #1;
    n_checks++; if (lookup_hit !== 1'b0) begin n_fail++; $display("FAIL fwd8_hit: got %b want 0", lookup_hit); end
    lookup_addr = 5'd0;
    #1;
    n_checks++; if (lookup_hit !== 1'b0) begin n_fail++; $display("FAIL fwd0_hit: got %b want 0", lookup_hit); end
    // Head entry (dest 9) remains visible while it pops.
    drain_en = 1'b1; lookup_addr = 5'd9;
#1;
`ifdef WBQ_FORWARD_EN
    exp_val = 32'h33;
`endif
    n_checks++; if (lookup_hit !== exp_hit) begin n_fail++; $display("FAIL fwd_head_hit: got %b want %b", lookup_hit, exp_hit); end
    n_checks++; if (lookup_val !== exp_val) begin n_fail++; $display("FAIL fwd_head_val: got %h want %h", lookup_val, exp_val); end
    for (int k = 0; k < 3; k++) tick();
    settle();
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL fwd_drain: got %0d want 0", count); end
  endtask

  task automatic test_reset_mid();
    drain_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_dest = ADDR_W'(k + 2); in_val = $urandom;
      settle();
      tick();
    end
    in_valid = 1'b0;
    settle();
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL mid_pre_count: got %0d want 3", count); end
    drain_en = 1'b1;
    rst = 1'b1;
    #1;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL mid_count: got %0d want 0", count); end
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL mid_we: got %b want 0", rf_we); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b want 1", in_ready); end
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      settle();
      n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL mid_post_we[%0d]: got %b want 0", k, rf_we); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    ent_t seq [12];
    int   out_i = 0;
    foreach (seq[i]) seq[i] = '{dest: ADDR_W'($urandom_range(1, 31)), val: $urandom};
    drain_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_dest = seq[k].dest; in_val = seq[k].val;
      settle();
      tick();
    end
    drain_en = 1'b1;
    for (int k = 2; k < 14; k++) begin
      in_valid = (k < 12); in_dest = seq[k % 12].dest; in_val = seq[k % 12].val;
      settle();
      if (k < 12) begin
        n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL b2b_count[%0d]: got %0d want 2", k, count); end
      end
      n_checks++; if (rf_dest !== seq[out_i].dest) begin n_fail++; $display("FAIL b2b_dest[%0d]: got %0d want %0d", out_i, rf_dest, seq[out_i].dest); end
      n_checks++; if (rf_val !== seq[out_i].val) begin n_fail++; $display("FAIL b2b_val[%0d]: got %h want %h", out_i, rf_val, seq[out_i].val); end
      out_i++;
      tick();
    end
    in_valid = 1'b0;
    settle();
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL b2b_empty: got %0d want 0", count); end
  endtask

  task automatic test_random();
    logic              exp_hit;
    logic [DATA_W-1:0] exp_val;
    for (int c = 0; c < 400; c++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      in_dest     = ADDR_W'($urandom_range(0, 7));
      in_val      = $urandom;
      drain_en    = ($urandom_range(0, 9) < 6);
      lookup_addr = ADDR_W'($urandom_range(0, 7));
      settle();
      model_lookup(lookup_addr, exp_hit, exp_val);
      n_checks++; if (count !== 3'(q.size())) begin n_fail++; $display("FAIL rnd_count[%0d]: got %0d want %0d", c, count, q.size()); end
      n_checks++; if (in_ready !== (q.size() < DEPTH)) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b want %b", c, in_ready, q.size() < DEPTH); end
      n_checks++; if (rf_we !== (q.size() != 0 && drain_en)) begin n_fail++; $display("FAIL rnd_we[%0d]: got %b", c, rf_we); end
      if (q.size() != 0) begin
        n_checks++; if (rf_dest !== q[0].dest) begin n_fail++; $display("FAIL rnd_dest[%0d]: got %0d want %0d", c, rf_dest, q[0].dest); end
        n_checks++; if (rf_val !== q[0].val) begin n_fail++; $display("FAIL rnd_val[%0d]: got %h want %h", c, rf_val, q[0].val); end
      end else begin
        n_checks++; if (rf_dest !== '0 || rf_val !== '0) begin n_fail++; $display("FAIL rnd_empty_out[%0d]: got %0d/%h want 0/0", c, rf_dest, rf_val); end
      end
      n_checks++; if (lookup_hit !== exp_hit) begin n_fail++; $display("FAIL rnd_hit[%0d]: got %b want %b", c, lookup_hit, exp_hit); end
      n_checks++; if (lookup_val !== exp_val) begin n_fail++; $display("FAIL rnd_lval[%0d]: got %h want %h", c, lookup_val, exp_val); end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_dest = '0; in_val = '0; drain_en = 1'b0; lookup_addr = '0;
    test_reset();
    test_single();
    test_fill_full();
    test_dest_zero();
    test_forward();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_write_queue.md
WB_WRITE_QUEUE -- requirements
Module: wb_write_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; power of two, 2..16.
REQ-002 Parameter DATA_W, default 32, write-value width.
REQ-003 Parameter ADDR_W, default 5, register index width.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  1  writeback request present.
REQ-007 in_ready  output  1  queue can accept a request.
REQ-008 in_dest  input  ADDR_W  destination register index.
REQ-009 in_val  input  DATA_W  value to write.
REQ-010 drain_en  input  1  register file may accept a write this cycle.
REQ-011 rf_we  output  1  write enable to the register file write port.
REQ-012 rf_dest  output  ADDR_W  write address to the register file.
REQ-013 rf_val  output  DATA_W  write data to the register file.
REQ-014 lookup_addr  input  ADDR_W  register index probed by the decode stage.
REQ-015 lookup_hit  output  1  probed register has a pending queued write.
REQ-016 lookup_val  output  DATA_W  youngest pending value for lookup_addr.
REQ-017 count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-018 Circular FIFO: head pointer, tail pointer, occupancy counter; pointers wrap modulo DEPTH.
REQ-019 in_ready = (count < DEPTH); combinational from registered state only, never from in_valid.
REQ-020 Accept when in_valid && in_ready at a rising edge; entry {in_dest, in_val} written at tail, tail advances.
REQ-021 Request with in_dest == 0 is accepted (handshake completes) but not enqueued; count unchanged.
REQ-022 rf_we = (count != 0) && drain_en; rf_dest/rf_val = head entry, combinational; rf_dest/rf_val = 0 when count == 0.
REQ-023 Pop at a rising edge when rf_we == 1; head advances.
REQ-024 Latency: request accepted at edge N into empty queue drives rf_we in the cycle after edge N; register file writes it at edge N+1 if drain_en.
REQ-025 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-026 Full queue: in_ready = 0 even if a pop occurs the same cycle; no push when full.
REQ-027 drain_en = 0: no pop; queue holds contents; accepts continue until full.
REQ-028 Entries drain strictly in acceptance order; a later write to the same register never overtakes an earlier one.
REQ-029 count is the exact occupancy after every edge; never exceeds DEPTH, never underflows.

Reset
REQ-030 rst asserted: head, tail, count = 0 immediately, independent of clk; in_ready = 1, rf_we = 0, lookup_hit = 0.
REQ-031 Reset mid-operation discards all queued entries; none is written to the register file after rst rises.
REQ-032 Entry storage need not be cleared; outputs never expose unoccupied entries.

Configuration
REQ-033 Macro WBQ_FORWARD_EN compiles in the lookup path.
REQ-034 With WBQ_FORWARD_EN: lookup combinationally searches occupied entries; lookup_hit = 1 if any matches lookup_addr; lookup_val = youngest matching entry; lookup_addr == 0 never hits.
REQ-035 Search covers the head entry even while it is being popped that cycle.
REQ-036 Without WBQ_FORWARD_EN: lookup_hit tied 0, lookup_val tied 0, no comparator logic; lookup_addr unused.

Verification
REQ-037 Empty queue, drain_en=1, push {dest=3, val=0xDEADBEEF} -> next cycle rf_we=1, rf_dest=3, rf_val=0xDEADBEEF; count returns to 0 after following edge.
REQ-038 drain_en=0, push 5 requests (DEPTH=4) -> first 4 accepted, in_ready=0 at count=4, 5th held; drain_en=1 -> writes emerge in order, one per cycle.
REQ-039 Push {dest=0, val=0x1234} -> in_ready stays 1, count stays 0, rf_we never asserts.
REQ-040 WBQ_FORWARD_EN, drain_en=0, push {7,0x11} then {7,0x22}, lookup_addr=7 -> lookup_hit=1, lookup_val=0x22; lookup_addr=8 -> lookup_hit=0.
REQ-041 count=3, assert rst between edges -> count=0, rf_we=0, in_ready=1 immediately; no rf write after release.
REQ-042 count=2, drain_en=1, push every cycle for 10 cycles -> count stays 2, pointers wrap, output order equals input order.
